// File: rtl/ram_lector_if.sv
// Bus bundle for ram_lector: ALU write port, read request port and read result.
interface ram_lector_if #(
    parameter int unsigned ANCHO    = 32,
    parameter int unsigned PROF_DIR = 5
);
    logic [ANCHO-1:0]    DatoE;
    logic [PROF_DIR-1:0] DirRam;
    logic                WE;
    logic [PROF_DIR-1:0] DirLec;
    logic                ReqLec;
    logic                ListoS;
    logic [ANCHO-1:0]    DatoS;
    logic                ValidoS;
    logic                Ocupado;

    // Memory side
    modport slave (
        input  DatoE, DirRam, WE, DirLec, ReqLec, ListoS,
        output DatoS, ValidoS, Ocupado
    );

    // Requester side (ALU / writeback path)
    modport master (
        output DatoE, DirRam, WE, DirLec, ReqLec, ListoS,
        input  DatoS, ValidoS, Ocupado
    );
endinterface

// File: rtl/ram_lector.sv
// Data RAM with clocked ALU write port, handshaked single-word read port and
// a post-reset clearing sequencer that blocks reads until memory is zeroed.
module ram_lector #(
    parameter int unsigned ANCHO    = 32,
    parameter int unsigned PROF_DIR = 5
) (
    input  logic          clk,
    input  logic          rst,
    ram_lector_if.slave   bus
);
    localparam int unsigned PROF = 1 << PROF_DIR;
    localparam int unsigned CW   = PROF_DIR + 1;

    typedef enum logic [1:0] {
        LIMPIA   = 2'd0,
        INACTIVO = 2'd1,
        ENTREGA  = 2'd2
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [CW-1:0]    contador_q, contador_d;
    logic [ANCHO-1:0] dato_s_q, dato_s_d;
    logic             valido_q, valido_d;
    logic             ocupado_q, ocupado_d;

    logic [ANCHO-1:0] memoria [PROF];

    logic                esc_c;
    logic [PROF_DIR-1:0] esc_dir_c;
    logic [ANCHO-1:0]    esc_dato_c;
    logic [ANCHO-1:0]    lect_c;

    // Write port mux: clearing sequencer owns the port during LIMPIA; nothing is written under reset
    always_comb begin
        esc_c      = 1'b0;
        esc_dir_c  = bus.DirRam;
        esc_dato_c = bus.DatoE;
        if (!rst) begin
            if (estado_q == LIMPIA) begin
                esc_c      = 1'b1;
                esc_dir_c  = contador_q[PROF_DIR-1:0];
                esc_dato_c = '0;
            end else begin
                esc_c      = bus.WE;
            end
        end
    end

    // Read data with write-first bypass for a same-edge write to the read address
    always_comb begin
        lect_c = memoria[bus.DirLec];
        if (bus.WE && (bus.DirRam == bus.DirLec)) begin
            lect_c = bus.DatoE;
        end
    end

    // Storage array; contents survive reset and are only zeroed by the sequencer
    always_ff @(posedge clk) begin
        if (esc_c) begin
            memoria[esc_dir_c] <= esc_dato_c;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        estado_d   = estado_q;
        contador_d = contador_q;
        dato_s_d   = dato_s_q;
        case (estado_q)
            LIMPIA: begin
                contador_d = contador_q + CW'(1);
                if (contador_q == CW'(PROF - 1)) begin
                    estado_d = INACTIVO;
                end
            end
            INACTIVO: begin
                if (bus.ReqLec) begin
                    dato_s_d = lect_c;
                    estado_d = ENTREGA;
                end
            end
            ENTREGA: begin
                if (bus.ListoS) begin
                    estado_d = INACTIVO;
                end
            end
            default: begin
                estado_d = LIMPIA;
            end
        endcase
        valido_d  = (estado_d == ENTREGA);
        ocupado_d = (estado_d != INACTIVO);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= LIMPIA;
            contador_q <= '0;
            dato_s_q   <= '0;
            valido_q   <= 1'b0;
            ocupado_q  <= 1'b1;
        end else begin
            estado_q   <= estado_d;
            contador_q <= contador_d;
            dato_s_q   <= dato_s_d;
            valido_q   <= valido_d;
            ocupado_q  <= ocupado_d;
        end
    end

    assign bus.DatoS   = dato_s_q;
    assign bus.ValidoS = valido_q;
    assign bus.Ocupado = ocupado_q;

endmodule

// File: doc/ram_lector.md
Name: ram_lector

Overview:
- Read side of the data RAM: a 2^PROF_DIR x ANCHO word store.
- The write port is the existing ALU write interface (DatoE/DirRam/WE), now clocked.
- Adds a handshaked read port that returns one word per request to the register-file writeback path.
- After reset, a sequencer clears the memory before any read is accepted.

Parameters:
ANCHO, 32, data word width in bits
PROF_DIR, 5, address width; depth = 2^PROF_DIR words

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
DatoE  input  ANCHO  write data from the ALU
DirRam  input  PROF_DIR  write address
WE  input  1  write enable, sampled on clk
DirLec  input  PROF_DIR  read address, sampled when the request is accepted
ReqLec  input  1  read request
ListoS  input  1  consumer ready for DatoS
DatoS  output  ANCHO  read data (registered)
ValidoS  output  1  DatoS holds a valid result
Ocupado  output  1  high while clearing or holding an undelivered result; requests are not accepted

Behaviour:
- Reset (rst=1 at a clk edge):
  - next state LIMPIA, clear counter = 0, DatoS = 0, ValidoS = 0, Ocupado = 1.
  - Memory contents are not touched by rst itself.
  - Reset mid-operation aborts any pending result; ValidoS drops the next cycle with no handshake.
- States: LIMPIA, INACTIVO, ENTREGA.
- LIMPIA:
  - Each cycle writes 0 to Memoria[contador], then increments contador.
  - After writing address 2^PROF_DIR-1, goes to INACTIVO. That is exactly 2^PROF_DIR = 32 cycles after rst deasserts.
  - WE and ReqLec are ignored; Ocupado = 1.
- INACTIVO:
  - Ocupado = 0, ValidoS = 0.
  - ReqLec = 1 accepts the request: DatoS <= Memoria[DirLec], ValidoS <= 1, next state ENTREGA.
  - Latency is 1 cycle from the accepting edge to ValidoS = 1.
- ENTREGA:
  - ValidoS = 1 and Ocupado = 1. DatoS is held stable until ValidoS = 1 and ListoS = 1 at a clk edge, then ValidoS <= 0 and next state INACTIVO.
  - A new request is accepted no earlier than the cycle after the handshake: maximum 1 read per 2 cycles.
  - ReqLec during ENTREGA is ignored, not queued.
- Writes:
  - Outside LIMPIA, WE = 1 writes Memoria[DirRam] <= DatoE on the clk edge, in any state.
  - Writes in ENTREGA do not alter the held DatoS (snapshot semantics).
- Simultaneous events:
  - Read accepted with WE = 1 and DirRam == DirLec on the same edge: DatoS returns the new DatoE (write-first bypass).
  - Different addresses: both take effect.
- Widths and addressing:
  - Addresses are unsigned with no out-of-range case; the full 2^PROF_DIR space is valid.
  - The clear counter is PROF_DIR+1 bits wide, so termination does not depend on wrap.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 2 cycles, then low, no requests; afterwards read address 7.
  - Required: Ocupado = 1 for exactly 32 cycles after rst falls, then 0. The read of address 7 returns DatoS = 0x00000000.
- Write then read:
  - Stimulus: WE = 1, DirRam = 3, DatoE = 0xDEADBEEF; next cycle ReqLec = 1, DirLec = 3, ListoS = 1.
  - Required: ValidoS = 1 one cycle after acceptance with DatoS = 0xDEADBEEF, then ValidoS = 0 the following cycle.
- Backpressure:
  - Stimulus: read address 3 with ListoS = 0 for 5 cycles; meanwhile WE writes 0x12345678 to address 3 and ReqLec toggles.
  - Required: DatoS stays 0xDEADBEEF and ValidoS = 1 for 5 cycles; no extra result appears after ListoS = 1.
- Same-edge bypass:
  - Stimulus: ReqLec = 1, DirLec = 9 together with WE = 1, DirRam = 9, DatoE = 0xA5A5A5A5.
  - Required: DatoS = 0xA5A5A5A5.
- Write during clear:
  - Stimulus: WE = 1, DirRam = 31, DatoE = 0xFFFFFFFF issued during LIMPIA; after clear, read address 31.
  - Required: returns 0 (the write was ignored).
- Reset mid-delivery:
  - Stimulus: assert rst while ValidoS = 1.
  - Required: next cycle ValidoS = 0, DatoS = 0, Ocupado = 1; a full 32-cycle clear follows; a later read of address 3 returns 0.
